// File: rtl/issue_scoreboard.sv
// Issue scoreboard: per-register pending-write counters gate decode-to-execute
// issue through a one-entry output slot with a valid/ready handshake.
module issue_scoreboard #(
    parameter int cRegSelBitW = 5,
    parameter int cPendW      = 2,
    parameter int cStallCntW  = 16
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iDecValid,
    input  logic [cRegSelBitW-1:0] iRs1Addr,
    input  logic [cRegSelBitW-1:0] iRs2Addr,
    input  logic [cRegSelBitW-1:0] iRdAddr,
    input  logic                   iUsesRs1,
    input  logic                   iUsesRs2,
    input  logic                   iWritesRd,
    output logic                   oDecReady,
    output logic                   oIssueValid,
    output logic [cRegSelBitW-1:0] oIssueRd,
    output logic                   oIssueWr,
    input  logic                   iExReady,
    input  logic                   iWbValid,
    input  logic [cRegSelBitW-1:0] iWbAddr,
    input  logic                   iFlush,
    output logic [cStallCntW-1:0]  oStallCnt,
    output logic                   oErr
);

    localparam int cNumRegs = 2 ** cRegSelBitW;

    logic [cPendW-1:0]      r_cnt    [cNumRegs];
    logic [cPendW-1:0]      w_cntNxt [cNumRegs];
    logic                   r_issueValid;
    logic [cRegSelBitW-1:0] r_issueRd;
    logic                   r_issueWr;
    logic [cStallCntW-1:0]  r_stallCnt;
    logic                   r_err;

    logic w_hazard;
    logic w_slotFree;
    logic w_accept;
    logic w_incEn;
    logic w_wbEn;
    logic w_flushDrop;
    logic w_errSet;

    // Hazard looks only at registered counters; a writeback is visible next cycle.
    always_comb begin
        w_hazard = 1'b0;
        if (iUsesRs1 && (iRs1Addr != '0) && (r_cnt[iRs1Addr] != '0))
            w_hazard = 1'b1;
        if (iUsesRs2 && (iRs2Addr != '0) && (r_cnt[iRs2Addr] != '0))
            w_hazard = 1'b1;
        if (iWritesRd && (iRdAddr != '0) && (r_cnt[iRdAddr] == '1))
            w_hazard = 1'b1;
    end

    assign w_slotFree  = !r_issueValid || iExReady;
    assign oDecReady   = !w_hazard && w_slotFree && !iFlush;
    assign w_accept    = iDecValid && oDecReady;
    assign w_incEn     = w_accept && iWritesRd && (iRdAddr != '0);
    assign w_wbEn      = iWbValid && (iWbAddr != '0);
    // A flushed instruction that would have written rd gives back its pending slot.
    assign w_flushDrop = iFlush && r_issueValid && r_issueWr && (r_issueRd != '0);

    // Next pending count per register: +1 on issue, -1 per writeback/flush drop, floor at 0.
    always_comb begin : cnt_next
        logic l_inc;
        logic l_decWb;
        logic l_decFl;
        w_errSet = 1'b0;
        for (int i = 0; i < cNumRegs; i++) begin
            w_cntNxt[i] = r_cnt[i];
            l_inc   = w_incEn     && (iRdAddr   == i[cRegSelBitW-1:0]);
            l_decWb = w_wbEn      && (iWbAddr   == i[cRegSelBitW-1:0]);
            l_decFl = w_flushDrop && (r_issueRd == i[cRegSelBitW-1:0]);
            if (l_inc) begin
                // Accept and flush drop are exclusive, so only a writeback can cancel the increment.
                if (!l_decWb)
                    w_cntNxt[i] = r_cnt[i] + 1'b1;
            end else if (l_decWb && l_decFl) begin
                if (r_cnt[i] >= cPendW'(2)) begin
                    w_cntNxt[i] = r_cnt[i] - cPendW'(2);
                end else begin
                    w_cntNxt[i] = '0;
                    w_errSet    = 1'b1;
                end
            end else if (l_decWb || l_decFl) begin
                if (r_cnt[i] != '0) begin
                    w_cntNxt[i] = r_cnt[i] - 1'b1;
                end else begin
                    w_errSet = 1'b1;
                end
            end
        end
    end

    // Pending counter array.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < cNumRegs; i++)
                r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < cNumRegs; i++)
                r_cnt[i] <= w_cntNxt[i];
        end
    end

    // Issue slot: flush empties it, accept loads it, consume empties it.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_issueValid <= 1'b0;
            r_issueRd    <= '0;
            r_issueWr    <= 1'b0;
        end else if (iFlush) begin
            r_issueValid <= 1'b0;
        end else if (w_accept) begin
            r_issueValid <= 1'b1;
            r_issueRd    <= iRdAddr;
            r_issueWr    <= iWritesRd;
        end else if (iExReady) begin
            r_issueValid <= 1'b0;
        end
    end

    // Hazard stall counter, saturating; slot-busy stalls are not counted.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)
            r_stallCnt <= '0;
        else if (iDecValid && w_hazard && !iFlush && (r_stallCnt != '1))
            r_stallCnt <= r_stallCnt + 1'b1;
    end

    // Sticky underflow error.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)
            r_err <= 1'b0;
        else if (w_errSet)
            r_err <= 1'b1;
    end

    assign oIssueValid = r_issueValid;
    assign oIssueRd    = r_issueRd;
    assign oIssueWr    = r_issueWr;
    assign oStallCnt   = r_stallCnt;
    assign oErr        = r_err;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed table, corner-case sequences and random
// traffic compared against a pending-count reference model.
module tb_issue_scoreboard;

    typedef struct packed {
        logic       dv;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       wr;
        logic       exr;
        logic       wbv;
        logic [4:0] wba;
        logic       fl;
    } in_t;

    typedef struct {
        in_t        in;
        logic       e_rdy;
        logic       e_v;
        logic [4:0] e_rd;
        logic       e_wr;
        int         e_stall;
        logic       e_err;
    } vec_t;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iDecValid;
    logic [4:0]  iRs1Addr, iRs2Addr, iRdAddr;
    logic        iUsesRs1, iUsesRs2, iWritesRd;
    logic        oDecReady;
    logic        oIssueValid;
    logic [4:0]  oIssueRd;
    logic        oIssueWr;
    logic        iExReady;
    logic        iWbValid;
    logic [4:0]  iWbAddr;
    logic        iFlush;
    logic [15:0] oStallCnt;
    logic        oErr;

    issue_scoreboard dut (
        .iClk(iClk), .iRst(iRst), .iDecValid(iDecValid),
        .iRs1Addr(iRs1Addr), .iRs2Addr(iRs2Addr), .iRdAddr(iRdAddr),
        .iUsesRs1(iUsesRs1), .iUsesRs2(iUsesRs2), .iWritesRd(iWritesRd),
        .oDecReady(oDecReady), .oIssueValid(oIssueValid), .oIssueRd(oIssueRd),
        .oIssueWr(oIssueWr), .iExReady(iExReady), .iWbValid(iWbValid),
        .iWbAddr(iWbAddr), .iFlush(iFlush), .oStallCnt(oStallCnt), .oErr(oErr)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;

    // Reference model state: how many writes are outstanding per register.
    int         pend [32];
    logic       m_v;
    logic [4:0] m_rd;
    logic       m_wr;
    int         m_stall;
    logic       m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input logic dv, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic u1, input logic u2,
                               input logic wr, input logic exr, input logic wbv,
                               input logic [4:0] wba, input logic fl);
        in_t v;
        v.dv = dv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.u1 = u1; v.u2 = u2;
        v.wr = wr; v.exr = exr; v.wbv = wbv; v.wba = wba; v.fl = fl;
        return v;
    endfunction

    function automatic logic m_haz(input in_t v);
        return (v.u1 && v.rs1 != 0 && pend[v.rs1] != 0) ||
               (v.u2 && v.rs2 != 0 && pend[v.rs2] != 0) ||
               (v.wr && v.rd  != 0 && pend[v.rd]  == 3);
    endfunction

    function automatic logic m_ready(input in_t v);
        return !m_haz(v) && (!m_v || v.exr) && !v.fl;
    endfunction

    function automatic void m_reset();
        foreach (pend[i]) pend[i] = 0;
        m_v = 0; m_rd = 0; m_wr = 0; m_stall = 0; m_err = 0;
    endfunction

    function automatic void m_update(input in_t v);
        int   net [32];
        logic haz;
        logic acc;
        haz = m_haz(v);
        acc = v.dv && m_ready(v);
        foreach (net[i]) net[i] = 0;
        if (acc && v.wr && v.rd != 0) net[v.rd]++;
        if (v.wbv && v.wba != 0) net[v.wba]--;
        if (v.fl && m_v && m_wr && m_rd != 0) net[m_rd]--;
        for (int r = 1; r < 32; r++) begin
            pend[r] += net[r];
            if (pend[r] < 0) begin
                pend[r] = 0;
                m_err = 1;
            end
        end
        if (v.dv && haz && !v.fl && m_stall < 65535) m_stall++;
        if (v.fl) m_v = 0;
        else if (acc) begin
            m_v = 1; m_rd = v.rd; m_wr = v.wr;
        end else if (v.exr) m_v = 0;
    endfunction

    task automatic drive(input in_t v);
        iDecValid = v.dv; iRs1Addr = v.rs1; iRs2Addr = v.rs2; iRdAddr = v.rd;
        iUsesRs1 = v.u1; iUsesRs2 = v.u2; iWritesRd = v.wr; iExReady = v.exr;
        iWbValid = v.wbv; iWbAddr = v.wba; iFlush = v.fl;
    endtask

    task automatic chk_regs(input string pfx);
        chk({pfx, "_valid"}, 32'(oIssueValid), 32'(m_v));
        chk({pfx, "_rd"},    32'(oIssueRd),    32'(m_rd));
        chk({pfx, "_wr"},    32'(oIssueWr),    32'(m_wr));
        chk({pfx, "_stall"}, 32'(oStallCnt),   32'(m_stall));
        chk({pfx, "_err"},   32'(oErr),        32'(m_err));
    endtask

    // One cycle: entered and left at a falling edge.
    task automatic step(input in_t v, output logic rdy);
        drive(v);
        #1;
        rdy = oDecReady;
        chk("model_ready", 32'(oDecReady), 32'(m_ready(v)));
        chk_regs("model");
        m_update(v);
        @(posedge iClk);
        @(negedge iClk);
    endtask

    vec_t tbl [9];
    in_t  idle;
    logic r;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // rs/rd/uses/wr/exr/wb/fl -> ready, then slot valid/rd/wr, stall, err after the edge
        tbl[0] = '{mk(1, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0), 1, 1, 3, 1, 0, 0};
        tbl[1] = '{mk(1, 0, 0, 5, 0, 0, 1, 1, 0, 0, 0), 1, 1, 5, 1, 0, 0};
        tbl[2] = '{mk(1, 5, 0, 6, 1, 0, 1, 1, 0, 0, 0), 0, 0, 5, 1, 1, 0};
        tbl[3] = '{mk(1, 5, 0, 6, 1, 0, 1, 1, 1, 5, 0), 0, 0, 5, 1, 2, 0};
        tbl[4] = '{mk(1, 5, 0, 6, 1, 0, 1, 1, 0, 0, 0), 1, 1, 6, 1, 2, 0};
        tbl[5] = '{mk(1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0), 1, 1, 0, 1, 2, 0};
        tbl[6] = '{mk(1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0), 1, 1, 0, 1, 2, 0};
        tbl[7] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0), 1, 0, 0, 1, 2, 0};
        tbl[8] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0), 1, 0, 0, 1, 2, 0};

        iRst = 1'b1;
        drive(idle);
        m_reset();
        #1;
        chk("rst_valid", 32'(oIssueValid), 0);
        chk("rst_rd",    32'(oIssueRd),    0);
        chk("rst_stall", 32'(oStallCnt),   0);
        chk("rst_err",   32'(oErr),        0);
        @(negedge iClk);
        @(negedge iClk);
        iRst = 1'b0;

        // Directed table
        for (int k = 0; k < 9; k++) begin
            step(tbl[k].in, r);
            chk($sformatf("tbl%0d_ready", k), 32'(r), 32'(tbl[k].e_rdy));
            chk($sformatf("tbl%0d_valid", k), 32'(oIssueValid), 32'(tbl[k].e_v));
            chk($sformatf("tbl%0d_rd", k),    32'(oIssueRd),    32'(tbl[k].e_rd));
            chk($sformatf("tbl%0d_wr", k),    32'(oIssueWr),    32'(tbl[k].e_wr));
            chk($sformatf("tbl%0d_stall", k), 32'(oStallCnt),   32'(tbl[k].e_stall));
            chk($sformatf("tbl%0d_err", k),   32'(oErr),        32'(tbl[k].e_err));
        end

        // Saturation of rd=7 at three pending writes
        for (int k = 0; k < 4; k++) begin
            step(mk(1, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0), r);
            chk("sat_ready", 32'(r), (k < 3) ? 1 : 0);
        end
        step(mk(1, 0, 0, 7, 0, 0, 1, 1, 1, 7, 0), r);
        chk("sat_wb_not_bypassed", 32'(r), 0);
        step(mk(1, 0, 0, 7, 0, 0, 1, 1, 1, 7, 0), r);
        chk("sat_acc_plus_wb", 32'(r), 1);
        step(mk(1, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0), r);
        chk("sat_refill", 32'(r), 1);
        step(mk(1, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0), r);
        chk("sat_full_again", 32'(r), 0);
        for (int k = 0; k < 3; k++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0), r);
        chk("sat_drain_err", 32'(oErr), 0);

        // Held slot with execute stalled, then flush
        step(mk(1, 0, 0, 10, 0, 0, 1, 0, 0, 0, 0), r);
        chk("hold_accept", 32'(r), 1);
        for (int k = 0; k < 2; k++) begin
            step(mk(1, 0, 0, 11, 0, 0, 1, 0, 0, 0, 0), r);
            chk("hold_ready", 32'(r), 0);
            chk("hold_valid", 32'(oIssueValid), 1);
            chk("hold_rd", 32'(oIssueRd), 10);
        end
        step(mk(1, 0, 0, 11, 0, 0, 1, 1, 0, 0, 1), r);
        chk("flush_ready", 32'(r), 0);
        chk("flush_valid", 32'(oIssueValid), 0);
        step(mk(1, 10, 0, 0, 1, 0, 0, 1, 0, 0, 0), r);
        chk("flush_released", 32'(r), 1);
        chk("flush_no_err", 32'(oErr), 0);

        // Underflow error is sticky
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0), r);
        chk("err_set", 32'(oErr), 1);
        step(idle, r);
        chk("err_sticky", 32'(oErr), 1);

        // Asynchronous reset in the middle of a stall
        step(mk(1, 0, 0, 12, 0, 0, 1, 1, 0, 0, 0), r);
        for (int k = 0; k < 2; k++) begin
            step(mk(1, 12, 0, 0, 1, 0, 0, 1, 0, 0, 0), r);
            chk("pre_rst_stall", 32'(r), 0);
        end
        chk("pre_rst_cnt", 32'(oStallCnt), 32'(m_stall));
        #2;
        iRst = 1'b1;
        #1;
        m_reset();
        chk("mid_rst_valid", 32'(oIssueValid), 0);
        chk("mid_rst_stall", 32'(oStallCnt), 0);
        chk("mid_rst_err",   32'(oErr), 0);
        @(negedge iClk);
        iRst = 1'b0;
        step(mk(1, 12, 0, 0, 1, 0, 0, 1, 0, 0, 0), r);
        chk("post_rst_ready", 32'(r), 1);

        // Random traffic on a narrow register window to force hazards
        for (int k = 0; k < 3000; k++) begin
            in_t v;
            v = mk($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4,
                   5'($urandom_range(0, 7)), $urandom_range(0, 19) == 0);
            step(v, r);
            if (k == 1500) begin
                iRst = 1'b1;
                m_reset();
                @(negedge iClk);
                iRst = 1'b0;
            end
        end
        chk_regs("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue controller between the instruction decoder and the execute stage.
- Tracks outstanding register writes in a per-register pending counter (scoreboard).
- Stalls a decoded instruction while any source or destination register it uses is busy, then issues it into a one-entry output register with a valid/ready handshake to execute.
- Execute writeback retires pending writes; a flush drops the held slot.

Parameters:
- cRegSelBitW, 5, register address width (32 architectural registers, x0 hardwired).
- cPendW, 2, pending-counter width per register; saturation value is 2**cPendW-1 (3).
- cStallCntW, 16, width of the stall performance counter.

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  reset, asynchronous, active-high.
- iDecValid  in  1  decoder presents an instruction.
- iRs1Addr  in  cRegSelBitW  source 1 address.
- iRs2Addr  in  cRegSelBitW  source 2 address.
- iRdAddr  in  cRegSelBitW  destination address.
- iUsesRs1  in  1  instruction reads rs1.
- iUsesRs2  in  1  instruction reads rs2.
- iWritesRd  in  1  instruction writes rd.
- oDecReady  out  1  instruction accepted this cycle when high together with iDecValid.
- oIssueValid  out  1  issue slot holds an instruction.
- oIssueRd  out  cRegSelBitW  rd of the held instruction.
- oIssueWr  out  1  held instruction writes rd.
- iExReady  in  1  execute consumes the slot when high together with oIssueValid.
- iWbValid  in  1  writeback retires one pending write.
- iWbAddr  in  cRegSelBitW  register being retired.
- iFlush  in  1  drop the held slot and block acceptance this cycle.
- oStallCnt  out  cStallCntW  cycles stalled on a hazard, saturating.
- oErr  out  1  sticky: writeback to a register with zero pending.

Behaviour:
- Reset (async, iRst=1): all pending counters 0, oIssueValid 0, oIssueRd 0, oIssueWr 0, oStallCnt 0, oErr 0. Outputs hold these values while iRst is high. Reset mid-stall discards the held instruction with no writeback expected.
- Register x0 never counts as a hazard. Issuing or writing back address 0 never changes any counter.
- Hazard condition (combinational, from registered counters only; no same-cycle writeback bypass) — any of:
  - iUsesRs1 & rs1≠0 & cnt[rs1]≠0
  - iUsesRs2 & rs2≠0 & cnt[rs2]≠0
  - iWritesRd & rd≠0 & cnt[rd]=max
- slotFree = !oIssueValid | iExReady.
- oDecReady = !hazard & slotFree & !iFlush. It does not depend on iDecValid, except that hazard terms are evaluated on the current inputs.
- Accept (iDecValid & oDecReady): on the next edge, oIssueValid=1, oIssueRd=iRdAddr, oIssueWr=iWritesRd. If iWritesRd & rd≠0, cnt[rd] increments.
- Latency: decode-to-issue is 1 cycle when no hazard.
- Consume without accept: oIssueValid=0 next cycle. Counters are not touched on consume; the write stays pending until writeback.
- Held slot with iExReady=0: oIssueValid, oIssueRd and oIssueWr stay stable.
- Writeback (iWbValid & iWbAddr≠0):
  - cnt[iWbAddr] decrements.
  - If it is already 0, the counter stays 0 and oErr sets (sticky until reset).
- Increment and decrement to the same register in the same cycle: counter unchanged. A writeback that frees a stalling source is seen one cycle later.
- Flush (iFlush=1):
  - Next cycle oIssueValid=0.
  - If the slot was valid and oIssueWr & oIssueRd≠0, cnt[oIssueRd] decrements; this combines with any same-cycle writeback (net −2 allowed, floor 0, floor hit sets oErr).
  - No accept in the flush cycle.
  - Instructions already consumed by execute still write back normally.
- oStallCnt increments each cycle with iDecValid & hazard & !iFlush. It saturates at all-ones. Stalls due to !slotFree alone are not counted.
- Pending counters never wrap: saturation blocks issue via the hazard condition; underflow floors at 0.

Test Plan:
- Reset then iDecValid with rs1=1, rs2=2, rd=3, all uses set, iExReady=1 -> oDecReady=1; next cycle oIssueValid=1, oIssueRd=3, cnt[3]=1.
- Issue rd=5, then next instr reads rs1=5 -> oDecReady=0 and oStallCnt counts up. iWbValid with iWbAddr=5 in cycle N -> accept in cycle N+1, not N. oStallCnt equals the number of stall cycles.
- Instruction reading x0 and writing x0 repeatedly -> never stalls; all counters stay 0.
- Four instrs writing rd=7 with no writeback -> the first three accept (cnt=3); the fourth stalls until one iWbAddr=7 writeback. Same-cycle accept to rd=7 plus writeback to 7 leaves cnt unchanged.
- iExReady=0 with slot full -> oDecReady=0 and slot fields stable. Assert iFlush -> oIssueValid=0 next cycle, cnt[rd] decremented, no accept that cycle.
- iWbValid iWbAddr=9 with cnt[9]=0 -> oErr=1 and stays 1. Assert iRst mid-stall -> all counters, oIssueValid, oStallCnt and oErr clear immediately.
